truth_table_sequencer: RTL and testbench

//  Sequencer for the 3-input/3-output combinational circuit: on start it sweeps
//  the input vector {x,y,z} through all 2**N_IN codes and waits SETTLE_CYCLES per code.
//  It then captures {F1,F2,F3} into a packed truth-table register and pulses done.

---
 rtl/truth_table_sequencer.sv | 153 +++++++++++++++
 tb/tb_truth_table_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps {x,y,z} through every input code of a small
// combinational circuit and captures {F1,F2,F3} into a packed truth table.
//
// Optional feature: define TT_CHECK_EN to compare each captured entry with an
// expected table. The first mismatching code of a sweep is reported.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high
//   start       in   begin a sweep; sampled only while idle
//   xyz_out     out  {x,y,z} driven into the circuit (x is the MSB)
//   f_in        in   {F1,F2,F3} from the circuit (F1 is the MSB)
//   busy        out  high from start acceptance until done
//   done        out  one-cycle pulse at sweep completion
//   table_out   out  entry v at [v*N_OUT +: N_OUT]
//   table_valid out  table_out holds a complete sweep
//   exp_table   in   (TT_CHECK_EN) expected table, same packing as table_out
//   err         out  (TT_CHECK_EN) a mismatch was seen in this sweep
//   err_idx     out  (TT_CHECK_EN) code of the first mismatch
`timescale 1ns/1ps

module truth_table_sequencer #(
    parameter int N_IN          = 3,
    parameter int N_OUT         = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic [N_IN-1:0]             xyz_out,
    input  logic [N_OUT-1:0]            f_in,
    output logic                        busy,
    output logic                        done,
    output logic [N_OUT*(2**N_IN)-1:0]  table_out,
    output logic                        table_valid
`ifdef TT_CHECK_EN
    ,
    input  logic [N_OUT*(2**N_IN)-1:0]  exp_table,
    output logic                        err,
    output logic [N_IN-1:0]             err_idx
`endif
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0] VEC_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [N_IN-1:0] vec;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            capture;

    // The applied code is the sweep index itself; it only moves on the
    // transitions into SETTLE, so it is held through CAPTURE and after DONE.
    assign xyz_out = vec;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                capture   = 1'b1;
                state_nxt = (vec == VEC_MAX) ? DONE : SETTLE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vec         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            table_out   <= '0;
            table_valid <= 1'b0;
        end else begin
            if (accept) begin
                vec         <= '0;
                cnt         <= '0;
                busy        <= 1'b1;
                table_valid <= 1'b0;
            end
            if (state == SETTLE && cnt != CNT_LAST) begin
                cnt <= cnt + CW'(1);
            end
            if (capture) begin
                table_out[vec*N_OUT +: N_OUT] <= f_in;
                cnt <= '0;
                // At the last code DONE follows, so vec never wraps.
                if (vec != VEC_MAX) begin
                    vec <= vec + N_IN'(1);
                end
            end
            if (done) begin
                busy        <= 1'b0;
                table_valid <= 1'b1;
            end
        end
    end

`ifdef TT_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err     <= 1'b0;
            err_idx <= '0;
        end else if (accept) begin
            err     <= 1'b0;
            err_idx <= '0;
        end else if (capture && !err &&
                     f_in != exp_table[vec*N_OUT +: N_OUT]) begin
            err     <= 1'b1;
            err_idx <= vec;
        end
    end
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: table-driven and randomized checks of the
// truth-table sweep against a table computed directly from circuit models.
`timescale 1ns/1ps

module tb_truth_table_sequencer;

    localparam int S     = 2;
    localparam int NC    = 8;
    localparam int SWEEP = NC * (S + 1);

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  xyz_out;
    logic [2:0]  f_in;
    logic        busy;
    logic        done;
    logic [23:0] table_out;
    logic        table_valid;
`ifdef TT_CHECK_EN
    logic [23:0] exp_table;
    logic        err;
    logic [2:0]  err_idx;
`endif

    int          n_chk = 0;
    int          n_fail = 0;
    int          mode = 0;
    int          bad_code = -1;
    logic [23:0] rtbl = '0;

    always #5 clk = ~clk;

    truth_table_sequencer #(
        .N_IN(3),
        .N_OUT(3),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .xyz_out(xyz_out),
        .f_in(f_in),
        .busy(busy),
        .done(done),
        .table_out(table_out),
        .table_valid(table_valid)
`ifdef TT_CHECK_EN
        ,
        .exp_table(exp_table),
        .err(err),
        .err_idx(err_idx)
`endif
    );

    // Circuit models: 0 = identity, 1 = {x^y^z, x&y, y|z}, else lookup table.
    function automatic logic [2:0] circ(input int m, input logic [2:0] v,
                                        input logic [23:0] rt);
        logic x, y, z;
        {x, y, z} = v;
        case (m)
            0:       return v;
            1:       return {x ^ y ^ z, x & y, y | z};
            default: return rt[v*3 +: 3];
        endcase
    endfunction

    function automatic logic [23:0] golden(input int m, input logic [23:0] rt,
                                           input int bad);
        logic [23:0] t;
        t = '0;
        for (int v = 0; v < NC; v++) begin
            t[v*3 +: 3] = (v == bad) ? 3'b000 : circ(m, 3'(v), rt);
        end
        return t;
    endfunction

    always_comb begin
        f_in = circ(mode, xyz_out, rtbl);
        if (int'(xyz_out) == bad_code) f_in = 3'b000;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Start a sweep and follow it cycle by cycle. c counts edges after E0;
    // values are sampled 1ns after each edge.
    task automatic run_sweep(input int extra_at, output int first_done,
                             output int n_done, output int xyz_bad,
                             output int ctl_bad);
        int exp_v;
        first_done = -1;
        n_done     = 0;
        xyz_bad    = 0;
        ctl_bad    = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c <= SWEEP + 3; c++) begin
            exp_v = (c < SWEEP) ? c / (S + 1) : NC - 1;
            if (int'(xyz_out) != exp_v) xyz_bad++;
            if (busy !== (c <= SWEEP)) ctl_bad++;
            if (table_valid !== (c > SWEEP)) ctl_bad++;
            if (done === 1'b1) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
            start = (c + 1 == extra_at);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic sweep_and_check(input string name, input int extra_at,
                                   input logic [23:0] exp_tbl);
        int fd, nd, xb, cb;
        run_sweep(extra_at, fd, nd, xb, cb);
        check({name, ".done_count"}, nd, 1);
        check({name, ".done_time"}, fd, SWEEP);
        check({name, ".xyz_seq"}, xb, 0);
        check({name, ".ctl_seq"}, cb, 0);
        check({name, ".table"}, table_out, exp_tbl);
        check({name, ".valid"}, table_valid, 1);
    endtask

    typedef struct {
        string       name;
        int          mode;
        int          extra_at;
        logic [23:0] exp_tbl;
    } vec_t;

    vec_t tv[4];

    initial begin
        int dn[$];
        tv[0] = '{"ident",      0, -1, 24'hFAC688};
        tv[1] = '{"ident_rest", 0, 10, 24'hFAC688};
        tv[2] = '{"logic",      1, -1, golden(1, '0, -1)};
        tv[3] = '{"logic_rest", 1, 25, golden(1, '0, -1)};

        reset = 1'b1;
        start = 1'b0;
`ifdef TT_CHECK_EN
        exp_table = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst.xyz", xyz_out, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.valid", table_valid, 0);
        check("rst.table", table_out, 0);

        for (int i = 0; i < 4; i++) begin
            mode = tv[i].mode;
            sweep_and_check(tv[i].name, tv[i].extra_at, tv[i].exp_tbl);
        end

        // Reset 13 edges into a sweep discards everything.
        mode = 1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst.busy", busy, 0);
        check("midrst.valid", table_valid, 0);
        check("midrst.table", table_out, 0);
        check("midrst.xyz", xyz_out, 0);
        check("midrst.done", done, 0);
        sweep_and_check("after_rst", -1, golden(1, '0, -1));

        // Start held high: second sweep accepted one idle cycle after done.
        mode = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 2 * SWEEP + 4; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dn.push_back(c);
            if (c == SWEEP + 1) check("held.idle_gap", busy, 0);
            if (c == SWEEP + 2) check("held.reaccept", busy, 1);
            if (c == 2 * SWEEP + 2) start = 1'b0;
        end
        check("held.done_n", dn.size(), 2);
        if (dn.size() == 2) begin
            check("held.done1", dn[0], SWEEP);
            check("held.done2", dn[1], 2 * SWEEP + 2);
        end
        check("held.table", table_out, 24'hFAC688);

        // Random circuits with a stray start somewhere in the busy window.
        for (int r = 0; r < 6; r++) begin
            mode = 2;
            rtbl = 24'($urandom);
            sweep_and_check($sformatf("rand%0d", r),
                            int'($urandom_range(1, SWEEP + 1)),
                            golden(2, rtbl, -1));
        end

`ifdef TT_CHECK_EN
        begin
            int fd, nd, xb, cb;
            mode = 0;
            exp_table = 24'hFAC688;
            bad_code = 5;
            run_sweep(-1, fd, nd, xb, cb);
            check("chk.err", err, 1);
            check("chk.err_idx", err_idx, 5);
            check("chk.table", table_out, golden(0, '0, 5));
            bad_code = -1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            check("chk.err_clr", err, 0);
            repeat (SWEEP + 2) @(posedge clk);
            #1;
            check("chk.err_clean", err, 0);
            check("chk.valid", table_valid, 1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
